// File: rtl/sp_pkg.sv
// sp_pkg: shared types and constants for the SP ASCON engine arbiter.
`default_nettype none

package sp_pkg;

  localparam int unsigned CHUNK_CNT_W = 4;

  typedef enum logic {
    ASC_DEC = 1'b0,
    ASC_ENC = 1'b1
  } asc_mode_e;

  typedef logic [2:0] arb_state_e;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] GRANT = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] START = 3'd3;
  localparam logic [2:0] RUN   = 3'd4;
  localparam logic [2:0] RESP  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/sp_rr_arb2.sv
// sp_rr_arb2: two-way round-robin arbiter; ties go to the side not granted last.
`default_nettype none

module sp_rr_arb2
  import sp_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      req_dec_i,
  input  logic      req_enc_i,
  input  logic      gnt_en_i,
  output logic      gnt_vld_o,
  output asc_mode_e gnt_sel_o
);

  asc_mode_e last_grant_q, last_grant_d;

  always_comb begin
    gnt_vld_o = gnt_en_i && (req_dec_i || req_enc_i);
    if (req_dec_i && req_enc_i) begin
      gnt_sel_o = (last_grant_q == ASC_ENC) ? ASC_DEC : ASC_ENC;
    end else if (req_dec_i) begin
      gnt_sel_o = ASC_DEC;
    end else begin
      gnt_sel_o = ASC_ENC;
    end
    last_grant_d = gnt_vld_o ? gnt_sel_o : last_grant_q;
  end

  // Reset to ENC so decrypt wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= ASC_ENC;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sp_ascon_arbiter.sv
// sp_ascon_arbiter: shares one ASCON engine between the SCL decrypt and SCS encrypt paths.
// Optional RUN-state watchdog enabled by defining SP_ASCON_TIMEOUT_EN.
`default_nettype none

module sp_ascon_arbiter
  import sp_pkg::*;
#(
  parameter int unsigned NUM_CHUNKS     = 6,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   dec_req_i,
  input  logic                   enc_req_i,
  output logic                   dec_gnt_o,
  output logic                   enc_gnt_o,
  input  logic                   chunk_vld_i,
  output logic [CHUNK_CNT_W-1:0] chunk_cnt_o,
  output logic                   asc_start_o,
  output logic                   asc_mode_o,
  input  logic                   asc_busy_i,
  input  logic                   asc_fail_i,
  output logic                   dec_done_o,
  output logic                   enc_done_o,
  output logic                   fail_o,
  output logic                   asc_abort_o
);

  localparam logic [CHUNK_CNT_W-1:0] CHUNK_TGT = CHUNK_CNT_W'(NUM_CHUNKS);

  if ((NUM_CHUNKS < 1) || (NUM_CHUNKS > 15) || (TIMEOUT_CYCLES < 2)) begin : g_bad_cfg
    $error("sp_ascon_arbiter: NUM_CHUNKS must be 1..15 and TIMEOUT_CYCLES >= 2");
  end

  arb_state_e             state_q, state_d;
  asc_mode_e              owner_q, owner_d;
  logic [CHUNK_CNT_W-1:0] cnt_q, cnt_d;
  logic                   seen_q, seen_d;
  logic                   fail_q, fail_d;
  logic                   gnt_vld;
  asc_mode_e              gnt_sel;
  logic                   start;

`ifdef SP_ASCON_TIMEOUT_EN
  localparam int unsigned      TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             abort_q, abort_d;
`endif

  sp_rr_arb2 u_rr_arb2 (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_dec_i (dec_req_i),
    .req_enc_i (enc_req_i),
    .gnt_en_i  (state_q == IDLE),
    .gnt_vld_o (gnt_vld),
    .gnt_sel_o (gnt_sel)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    fail_d  = fail_q;
    start   = 1'b0;
`ifdef SP_ASCON_TIMEOUT_EN
    tmo_d   = tmo_q;
    abort_d = abort_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          state_d = GRANT;
          owner_d = gnt_sel;
          fail_d  = 1'b0;
`ifdef SP_ASCON_TIMEOUT_EN
          abort_d = 1'b0;
`endif
        end
      end
      GRANT: state_d = (owner_q == ASC_DEC) ? LOAD : START;
      LOAD: begin
        if (chunk_vld_i && (cnt_q != CHUNK_TGT)) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (cnt_d == CHUNK_TGT) begin
          state_d = START;
        end
      end
      START: begin
        // Hold off the pulse while the engine still reports busy.
        if (!asc_busy_i) begin
          start   = 1'b1;
          state_d = RUN;
          seen_d  = 1'b0;
`ifdef SP_ASCON_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      RUN: begin
        if (asc_busy_i) begin
          seen_d = 1'b1;
        end
        if (seen_q && !asc_busy_i) begin
          fail_d  = asc_fail_i;
          state_d = RESP;
        end
`ifdef SP_ASCON_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          fail_d  = 1'b1;
          abort_d = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= ASC_DEC;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      fail_q  <= 1'b0;
`ifdef SP_ASCON_TIMEOUT_EN
      tmo_q   <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      fail_q  <= fail_d;
`ifdef SP_ASCON_TIMEOUT_EN
      tmo_q   <= tmo_d;
      abort_q <= abort_d;
`endif
    end
  end

  logic active, resp;
  assign active      = (state_q != IDLE);
  assign resp        = (state_q == RESP);
  assign dec_gnt_o   = active && (owner_q == ASC_DEC);
  assign enc_gnt_o   = active && (owner_q == ASC_ENC);
  assign asc_mode_o  = active && (owner_q == ASC_ENC);
  assign chunk_cnt_o = cnt_q;
  assign asc_start_o = start;
  assign dec_done_o  = resp && (owner_q == ASC_DEC);
  assign enc_done_o  = resp && (owner_q == ASC_ENC);
  assign fail_o      = resp && fail_q;
`ifdef SP_ASCON_TIMEOUT_EN
  assign asc_abort_o = resp && abort_q;
`else
  assign asc_abort_o = 1'b0;
`endif

  a_gnt_mutex: assert property (@(posedge clk_i) disable iff (!rst_ni) !(dec_gnt_o && enc_gnt_o));

endmodule

`default_nettype wire
